// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: single-outstanding IM fetch, AdEL detection, F/D pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter logic [31:0] PC_MIN    = 32'h0000_3000,
    parameter logic [31:0] PC_MAX    = 32'h0000_6FFC,
    parameter logic [4:0]  ADEL_CODE = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic        stall,
    input  logic        Req,
    input  logic        D_eret,
    input  logic        F_BD,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_rvalid,
    output logic        F_stall,
    output logic [31:0] D_PC,
    output logic [31:0] D_instruction,
    output logic        D_valid,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state, next_state;
    logic [31:0] hold_data;
    logic [4:0]  hold_code;

    logic        illegal;
    logic        flush;
    logic        ready;
    logic        fire;
    logic [31:0] data;
    logic [4:0]  code;

    always_comb begin
        illegal    = (F_PC[1:0] != 2'b00) || (F_PC < PC_MIN) || (F_PC > PC_MAX);
        flush      = Req || D_eret;
        next_state = state;
        ready      = 1'b0;
        data       = 32'h0;
        code       = 5'd0;
        im_req     = 1'b0;
        im_addr    = 32'h0;

        case (state)
            S_ISSUE: begin
                if (illegal) begin
                    ready = 1'b1;
                    code  = ADEL_CODE;
                end else if (!flush) begin
                    // Never launch a request on a flush cycle: the PC is about to be redirected.
                    im_req     = 1'b1;
                    im_addr    = F_PC;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    ready = 1'b1;
                    data  = im_rdata;
                end
            end
            S_HOLD: begin
                ready = 1'b1;
                data  = hold_data;
                code  = hold_code;
            end
            S_DROP: begin
                if (im_rvalid) begin
                    next_state = S_ISSUE;
                end
            end
            default: next_state = S_ISSUE;
        endcase

        if (flush) begin
            // A request still in flight must have its response swallowed before reissuing.
            if ((state == S_WAIT || state == S_DROP) && !im_rvalid) begin
                next_state = S_DROP;
            end else begin
                next_state = S_ISSUE;
            end
        end else if (ready) begin
            next_state = stall ? S_HOLD : S_ISSUE;
        end

        fire = ready && !stall && !flush && !reset;
        if (reset) begin
            im_req = 1'b0;
        end
        F_stall = !fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_ISSUE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= 32'h0;
            hold_code <= 5'd0;
        end else if (flush) begin
            hold_data <= 32'h0;
            hold_code <= 5'd0;
        end else if (ready && stall && state != S_HOLD) begin
            hold_data <= data;
            hold_code <= code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_PC          <= RESET_PC;
            D_instruction <= 32'h0;
            D_valid       <= 1'b0;
            D_ExcCode     <= 5'd0;
            D_BD          <= 1'b0;
        end else if (flush) begin
            D_PC          <= Req ? EXC_PC : F_PC;
            D_instruction <= 32'h0;
            D_valid       <= 1'b0;
            D_ExcCode     <= 5'd0;
            D_BD          <= 1'b0;
        end else if (fire) begin
            D_PC          <= F_PC;
            D_instruction <= data;
            D_valid       <= 1'b1;
            D_ExcCode     <= code;
            D_BD          <= F_BD;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] F_PC;
    logic        stall;
    logic        Req;
    logic        D_eret;
    logic        F_BD;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_rvalid;
    logic        F_stall;
    logic [31:0] D_PC;
    logic [31:0] D_instruction;
    logic        D_valid;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .stall(stall), .Req(Req),
        .D_eret(D_eret), .F_BD(F_BD), .im_req(im_req), .im_addr(im_addr),
        .im_rdata(im_rdata), .im_rvalid(im_rvalid), .F_stall(F_stall),
        .D_PC(D_PC), .D_instruction(D_instruction), .D_valid(D_valid),
        .D_ExcCode(D_ExcCode), .D_BD(D_BD)
    );

    always #5 clk = ~clk;

    // Instruction memory with programmable response latency
    int          lat;
    int          cnt;
    logic        pend;
    logic [31:0] paddr;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h3000) return 32'h3C01_1234;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else begin
            if (pend) begin
                if (cnt <= 1) pend <= 1'b0;
                else          cnt  <= cnt - 1;
            end
            if (im_req) begin
                pend  <= 1'b1;
                cnt   <= lat;
                paddr <= im_addr;
            end
        end
    end

    assign im_rvalid = pend && (cnt == 1);
    assign im_rdata  = im_rvalid ? im_word(paddr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        int          lat;
        logic [31:0] instr;
        logic [4:0]  exc;
        int          reqs;
        int          cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic fetch(input vec_t v);
        int reqs = 0;
        int cyc  = -1;
        bit fired = 0;
        F_PC  = v.pc;
        F_BD  = v.bd;
        lat   = v.lat;
        stall = 1'b0;
        for (int i = 0; i < 12 && !fired; i++) begin
            @(negedge clk);
            if (im_req) begin
                reqs++;
                chk("im_addr", im_addr, v.pc);
            end
            if (!F_stall) begin
                fired = 1;
                cyc   = i;
            end
            @(posedge clk);
            #1;
        end
        chk("fire_seen", 32'(fired), 32'd1);
        chk("fire_cycle", 32'(cyc), 32'(v.cyc));
        chk("req_count", 32'(reqs), 32'(v.reqs));
        chk("D_PC", D_PC, v.pc);
        chk("D_instruction", D_instruction, v.instr);
        chk("D_valid", 32'(D_valid), 32'd1);
        chk("D_ExcCode", 32'(D_ExcCode), 32'(v.exc));
        chk("D_BD", 32'(D_BD), 32'(v.bd));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_im_req"}, 32'(im_req), 32'd0);
        chk({tag, "_F_stall"}, 32'(F_stall), 32'd1);
        chk({tag, "_D_PC"}, D_PC, 32'h3000);
        chk({tag, "_D_instr"}, D_instruction, 32'h0);
        chk({tag, "_D_valid"}, 32'(D_valid), 32'd0);
        chk({tag, "_D_Exc"}, 32'(D_ExcCode), 32'd0);
        chk({tag, "_D_BD"}, 32'(D_BD), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h3000, 1'b0, 1, 32'h3C01_1234, 5'd0, 1, 1};
        vecs[1] = '{32'h3004, 1'b0, 2, 32'h3004_CFFB, 5'd0, 1, 2};
        vecs[2] = '{32'h3002, 1'b0, 1, 32'h0,         5'd4, 0, 0};
        vecs[3] = '{32'h7000, 1'b0, 1, 32'h0,         5'd4, 0, 0};
        vecs[4] = '{32'h3008, 1'b1, 1, 32'h3008_CFF7, 5'd0, 1, 1};
        vecs[5] = '{32'h2FFC, 1'b0, 1, 32'h0,         5'd4, 0, 0};
        vecs[6] = '{32'h6FFC, 1'b0, 1, 32'h6FFC_9003, 5'd0, 1, 1};

        reset = 1'b1; F_PC = 32'h0; stall = 1'b0; Req = 1'b0; D_eret = 1'b0; F_BD = 1'b0; lat = 1;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) fetch(vecs[i]);

        // Response arrives under stall: buffered in HOLD until stall drops
        F_PC = 32'h300C; F_BD = 1'b0; lat = 1; stall = 1'b1;
        @(negedge clk);
        chk("s3_req", 32'(im_req), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_F_stall", 32'(F_stall), 32'd1);
            chk("s3_im_req", 32'(im_req), 32'd0);
            chk("s3_D_PC", D_PC, 32'h6FFC);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        chk("s3_release_F_stall", 32'(F_stall), 32'd0);
        chk("s3_release_im_req", 32'(im_req), 32'd0);
        @(posedge clk); #1;
        chk("s3_D_instr", D_instruction, 32'h300C_CFF3);
        chk("s3_D_PC2", D_PC, 32'h300C);
        fetch('{32'h3010, 1'b0, 1, 32'h3010_CFEF, 5'd0, 1, 1});

        // Req while a 3-cycle request is outstanding
        F_PC = 32'h3014; lat = 3;
        @(negedge clk);
        chk("s4_req", 32'(im_req), 32'd1);
        @(posedge clk); #1;
        Req = 1'b1;
        @(negedge clk);
        chk("s4_flush_F_stall", 32'(F_stall), 32'd1);
        @(posedge clk); #1;
        Req = 1'b0;
        F_PC = 32'h4180;
        chk("s4_D_PC", D_PC, 32'h4180);
        chk("s4_D_instr", D_instruction, 32'h0);
        chk("s4_D_valid", 32'(D_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("s4_drop_im_req", 32'(im_req), 32'd0);
            chk("s4_drop_F_stall", 32'(F_stall), 32'd1);
            @(posedge clk); #1;
        end
        chk("s4_after_drop_valid", 32'(D_valid), 32'd0);
        chk("s4_after_drop_pc", D_PC, 32'h4180);
        fetch('{32'h4180, 1'b0, 1, 32'h4180_BE7F, 5'd0, 1, 1});

        // Delay-slot flag, then eret flush beating stall
        fetch('{32'h3018, 1'b1, 1, 32'h3018_CFE7, 5'd0, 1, 1});
        F_PC = 32'h301C; F_BD = 1'b0; stall = 1'b1; D_eret = 1'b1;
        @(negedge clk);
        chk("s5_im_req", 32'(im_req), 32'd0);
        chk("s5_F_stall", 32'(F_stall), 32'd1);
        @(posedge clk); #1;
        D_eret = 1'b0; stall = 1'b0;
        chk("s5_D_valid", 32'(D_valid), 32'd0);
        chk("s5_D_PC", D_PC, 32'h301C);
        chk("s5_D_BD", 32'(D_BD), 32'd0);
        chk("s5_D_instr", D_instruction, 32'h0);

        // Asynchronous reset in the middle of WAIT
        fetch('{32'h3020, 1'b0, 2, 32'h3020_CFDF, 5'd0, 1, 2});
        F_PC = 32'h3024; lat = 3;
        @(negedge clk);
        chk("s6_req", 32'(im_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("s6");
        @(posedge clk); #1;
        reset = 1'b0;
        fetch(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
